// File: rtl/sd_spi_engine.sv
// SPI-mode SD card command/response engine: sends a 6-byte command, collects an
// R1..R7 response and optionally a data block, all through one byte-serial SPI mode 0 engine.
module sd_spi_engine #(
    parameter int CLK_DIV     = 4,
    parameter int NCR_MAX     = 8,
    parameter int TOKEN_MAX   = 64,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] cmd,
    input  logic [2:0]  resp_len,
    input  logic        read_block,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [39:0] resp,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        sd_sclk,
    output logic        sd_mosi,
    output logic        sd_cs_n,
    input  logic        sd_miso
);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_R, RESP, WAIT_TOK, DATA, CRC, FINISH
    } state_t;

    state_t      state, state_next;
    logic        timeout_next;

    logic [15:0] div_cnt;
    logic [3:0]  bit_cnt;
    logic [12:0] byte_cnt;
    logic [6:0]  tx_sr;      // bits still to send after the one on sd_mosi
    logic [7:0]  rx_sr;
    logic [39:0] cmd_rest;   // command bytes not yet loaded into tx_sr
    logic [2:0]  len_r;
    logic        blk_r;
    logic        r1_err;

    logic        tick, rise, fall, byte_end;

    assign tick     = (state != IDLE) && (div_cnt == 16'(CLK_DIV - 1));
    assign rise     = tick && !sd_sclk;
    assign fall     = tick && sd_sclk;
    // A byte ends on the falling edge that follows its 8th rising edge.
    assign byte_end = fall && (bit_cnt == 4'd8);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            IDLE:     if (start) state_next = SEND;
            SEND:     if (byte_end && byte_cnt == 13'd5) state_next = WAIT_R;
            WAIT_R: begin
                if (byte_end) begin
                    if (!rx_sr[7]) begin
                        if (len_r != 3'd1)                     state_next = RESP;
                        else if (blk_r && rx_sr[6:0] == 7'd0)  state_next = WAIT_TOK;
                        else                                   state_next = FINISH;
                    end else if (byte_cnt == 13'(NCR_MAX - 1)) begin
                        state_next   = FINISH;
                        timeout_next = 1'b1;
                    end
                end
            end
            RESP: begin
                if (byte_end && byte_cnt == {10'd0, len_r - 3'd2})
                    state_next = (blk_r && !r1_err) ? WAIT_TOK : FINISH;
            end
            WAIT_TOK: begin
                if (byte_end) begin
                    if (rx_sr == 8'hFE) begin
                        state_next = DATA;
                    end else if (rx_sr != 8'hFF || byte_cnt == 13'(TOKEN_MAX - 1)) begin
                        state_next   = FINISH;
                        timeout_next = 1'b1;
                    end
                end
            end
            DATA:     if (byte_end && byte_cnt == 13'(BLOCK_BYTES - 1)) state_next = CRC;
            CRC:      if (byte_end && byte_cnt == 13'd1) state_next = FINISH;
            FINISH:   if (byte_end) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            resp       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sd_sclk    <= 1'b0;
            sd_mosi    <= 1'b1;
            sd_cs_n    <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sr      <= '1;
            rx_sr      <= '0;
            cmd_rest   <= '0;
            len_r      <= 3'd1;
            blk_r      <= 1'b0;
            r1_err     <= 1'b0;
        end else begin
            done       <= 1'b0;
            data_valid <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sd_sclk  <= 1'b0;
                if (start) begin
                    sd_mosi  <= cmd[47];
                    tx_sr    <= cmd[46:40];
                    cmd_rest <= cmd[39:0];
                    len_r    <= (resp_len == 3'd0 || resp_len > 3'd5) ? 3'd1 : resp_len;
                    blk_r    <= read_block;
                    r1_err   <= 1'b0;
                    resp     <= '0;
                    timeout  <= 1'b0;
                    busy     <= 1'b1;
                    sd_cs_n  <= 1'b0;
                end
            end else begin
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                if (rise) begin
                    sd_sclk <= 1'b1;
                    rx_sr   <= {rx_sr[6:0], sd_miso};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (state == DATA && bit_cnt == 4'd7) begin
                        data_out   <= {rx_sr[6:0], sd_miso};
                        data_valid <= 1'b1;
                    end
                end
                if (fall) begin
                    sd_sclk <= 1'b0;
                    if (byte_end) begin
                        bit_cnt  <= '0;
                        byte_cnt <= (state_next != state) ? 13'd0 : byte_cnt + 13'd1;
                        if (state == SEND && state_next == SEND) begin
                            sd_mosi  <= cmd_rest[39];
                            tx_sr    <= cmd_rest[38:32];
                            cmd_rest <= {cmd_rest[31:0], 8'hFF};
                        end else begin
                            sd_mosi <= 1'b1;
                            tx_sr   <= '1;
                        end
                        case (state)
                            WAIT_R: begin
                                if (!rx_sr[7]) begin
                                    resp   <= {resp[31:0], rx_sr};
                                    r1_err <= |rx_sr[6:0];
                                end
                            end
                            RESP:   resp <= {resp[31:0], rx_sr};
                            FINISH: begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                            default: ;
                        endcase
                        if (timeout_next)           timeout <= 1'b1;
                        if (state_next == FINISH)   sd_cs_n <= 1'b1;
                    end else begin
                        sd_mosi <= tx_sr[6];
                        tx_sr   <= {tx_sr[5:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Scoreboard bench for sd_spi_engine: a scripted SPI card model drives MISO, expected
// done/data results are queued at stimulus time and a monitor compares them as they appear.
module tb_sd_spi_engine;

    localparam int CLK_DIV     = 2;
    localparam int NCR_MAX     = 8;
    localparam int TOKEN_MAX   = 64;
    localparam int BLOCK_BYTES = 4;
    localparam int BYTE_CLKS   = 16 * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] cmd = '0;
    logic [2:0]  resp_len = 3'd1;
    logic        read_block = 1'b0;
    logic        busy, done, timeout, data_valid;
    logic [39:0] resp;
    logic [7:0]  data_out;
    logic        sd_sclk, sd_mosi, sd_cs_n, sd_miso;

    sd_spi_engine #(
        .CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX), .BLOCK_BYTES(BLOCK_BYTES)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cmd(cmd), .resp_len(resp_len),
        .read_block(read_block), .busy(busy), .done(done), .timeout(timeout), .resp(resp),
        .data_out(data_out), .data_valid(data_valid), .sd_sclk(sd_sclk), .sd_mosi(sd_mosi),
        .sd_cs_n(sd_cs_n), .sd_miso(sd_miso)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int dv_cnt   = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Card model: cur is the byte being shifted out, card_q the bytes that follow.
    logic [7:0] card_q[$];
    logic [7:0] mo_q[$];
    logic       cs_q[$];
    logic [7:0] cur = 8'hFF;
    logic [7:0] mo_sr = '0;
    logic [2:0] bitn = '0;

    assign sd_miso = cur[~bitn];

    always @(posedge sd_sclk) begin
        if (bitn == 3'd0) cs_q.push_back(sd_cs_n);
        mo_sr = {mo_sr[6:0], sd_mosi};
        if (bitn == 3'd7) mo_q.push_back(mo_sr);
        bitn = bitn + 3'd1;
    end

    always @(negedge sd_sclk) begin
        if (bitn == 3'd0) cur = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
    end

    task automatic card_arm(input logic [7:0] first);
        card_q.delete();
        mo_q.delete();
        cs_q.delete();
        cur  = first;
        bitn = '0;
    endtask

    task automatic card_push(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) card_q.push_back(b);
    endtask

    // Scoreboard
    typedef struct {
        logic [39:0] resp;
        logic        to;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_data[$];
    exp_t       mon_e;

    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("resp", resp, mon_e.resp);
                    check("timeout", timeout, mon_e.to);
                    check("busy_low_at_done", busy, 0);
                end
            end
            if (data_valid) begin
                dv_cnt++;
                check("data_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) check("data_out", data_out, exp_data.pop_front());
            end
        end
    end

    task automatic issue(input logic [47:0] c, input logic [2:0] l, input logic b);
        @(negedge clock);
        cmd = c; resp_len = l; read_block = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < bound) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({name, "_finished"}, done_cnt != base, 1);
    endtask

    task automatic expect_done(input logic [39:0] r, input logic to);
        exp_t e;
        e.resp = r;
        e.to   = to;
        exp_q.push_back(e);
    endtask

    // CMD0: card answers 0x01 on the second poll byte.
    task automatic run_cmd0(input string tag);
        logic [7:0] exp_cmd[6];
        exp_cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        card_arm(8'hFF);
        card_push(8'hFF, 6);
        card_push(8'h01, 1);
        expect_done(40'h00_0000_0001, 1'b0);
        issue(48'h40_0000_0000_95, 3'd1, 1'b0);
        wait_done(tag, 20 * BYTE_CLKS);
        check({tag, "_cycles"}, done_cyc - start_cyc, 9 * BYTE_CLKS);
        check({tag, "_nbytes"}, mo_q.size(), 9);
        for (int i = 0; i < 6; i++)
            if (i < mo_q.size()) check({tag, "_mosi"}, mo_q[i], exp_cmd[i]);
        if (mo_q.size() == 9) begin
            check({tag, "_poll_mosi"}, mo_q[6], 8'hFF);
            check({tag, "_cs_cmd"}, cs_q[5], 0);
            check({tag, "_cs_finish"}, cs_q[8], 1);
        end
    endtask

    int base_dv;
    int base_done;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_cs_n", sd_cs_n, 1);
        check("rst_sclk", sd_sclk, 0);
        check("rst_mosi", sd_mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_dv", data_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_resp", resp, 0);
        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("rst_over_start_busy", busy, 0);
        reset = 1'b0;
        @(negedge clock);

        run_cmd0("cmd0");

        // CMD8 with R7 response; extra starts while busy must be ignored.
        card_arm(8'hFF);
        card_push(8'hFF, 5);
        card_q.push_back(8'h01); card_q.push_back(8'h00); card_q.push_back(8'h00);
        card_q.push_back(8'h01); card_q.push_back(8'hAA);
        expect_done(40'h01_0000_01AA, 1'b0);
        issue(48'h48_0000_01AA_87, 3'd5, 1'b0);
        base_done = done_cnt;
        for (int k = 0; k < 3; k++) begin
            repeat (60) @(negedge clock);
            cmd = 48'h51_0000_0000_FF; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_done("cmd8", 20 * BYTE_CLKS);
        if (mo_q.size() != 0) check("cmd8_first_byte", mo_q[0], 8'h48);
        repeat (3 * BYTE_CLKS) @(negedge clock);
        check("cmd8_single_done", done_cnt - base_done, 1);
        check("cmd8_resp_hold", resp, 40'h01_0000_01AA);
        check("cmd8_idle_busy", busy, 0);

        // No response at all: NCR timeout.
        card_arm(8'hFF);
        expect_done(40'h0, 1'b1);
        issue(48'h40_0000_0000_95, 3'd1, 1'b0);
        wait_done("ncr_to", 30 * BYTE_CLKS);
        check("ncr_nbytes", mo_q.size(), 6 + NCR_MAX + 1);
        if (cs_q.size() == 6 + NCR_MAX + 1) begin
            check("ncr_cs_last_poll", cs_q[6 + NCR_MAX - 1], 0);
            check("ncr_cs_finish", cs_q[6 + NCR_MAX], 1);
        end
        check("ncr_timeout_hold", timeout, 1);

        // Block read: R1=00, three FF, token, four data bytes, CRC.
        card_arm(8'hFF);
        card_push(8'hFF, 5);
        card_q.push_back(8'h00);
        card_push(8'hFF, 3);
        card_q.push_back(8'hFE);
        card_q.push_back(8'h11); card_q.push_back(8'h22);
        card_q.push_back(8'h33); card_q.push_back(8'h44);
        card_q.push_back(8'hC1); card_q.push_back(8'hC2);
        exp_data.push_back(8'h11); exp_data.push_back(8'h22);
        exp_data.push_back(8'h33); exp_data.push_back(8'h44);
        expect_done(40'h0, 1'b0);
        base_dv = dv_cnt;
        issue(48'h51_0000_0000_FF, 3'd1, 1'b1);
        wait_done("blk", 40 * BYTE_CLKS);
        check("blk_strobes", dv_cnt - base_dv, 4);
        check("blk_nbytes", mo_q.size(), 18);

        // resp_len 0 acts as R1; an R1 error bit skips the block phase.
        card_arm(8'hFF);
        card_push(8'hFF, 5);
        card_q.push_back(8'h05);
        card_push(8'hFE, 3);
        expect_done(40'h05, 1'b0);
        base_dv = dv_cnt;
        issue(48'h51_0000_0000_FF, 3'd0, 1'b1);
        wait_done("r1err", 20 * BYTE_CLKS);
        check("r1err_nbytes", mo_q.size(), 8);
        check("r1err_no_data", dv_cnt - base_dv, 0);

        // Bad token byte ends the read with timeout.
        card_arm(8'hFF);
        card_push(8'hFF, 5);
        card_q.push_back(8'h00);
        card_q.push_back(8'hFF);
        card_q.push_back(8'h55);
        expect_done(40'h0, 1'b1);
        issue(48'h51_0000_0000_FF, 3'd1, 1'b1);
        wait_done("badtok", 20 * BYTE_CLKS);
        check("badtok_nbytes", mo_q.size(), 10);

        // Reset in the middle of data byte 2: abort, no done.
        card_arm(8'hFF);
        card_push(8'hFF, 5);
        card_q.push_back(8'h00);
        card_q.push_back(8'hFE);
        card_q.push_back(8'h11); card_q.push_back(8'h22);
        card_q.push_back(8'h33); card_q.push_back(8'h44);
        exp_data.push_back(8'h11);
        base_dv = dv_cnt;
        base_done = done_cnt;
        issue(48'h51_0000_0000_FF, 3'd1, 1'b1);
        for (int n = 0; n < 30 * BYTE_CLKS && dv_cnt == base_dv; n++) begin
            @(negedge clock);
            #1;
        end
        check("abort_first_byte_seen", dv_cnt - base_dv, 1);
        repeat (BYTE_CLKS / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_cs_n", sd_cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_sclk", sd_sclk, 0);
        check("abort_mosi", sd_mosi, 1);
        check("abort_resp", resp, 0);
        reset = 1'b0;
        repeat (10 * BYTE_CLKS) @(negedge clock);
        check("abort_no_done", done_cnt - base_done, 0);
        check("abort_no_more_data", dv_cnt - base_dv, 1);

        run_cmd0("cmd0_after_abort");

        repeat (20) @(negedge clock);
        check("exp_done_drained", exp_q.size(), 0);
        check("exp_data_drained", exp_data.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
